// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready producers.
// Optional FIFO_ARB_PRIO_EN gives requester 0 strict priority at IDLE arbitration.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 4,
  localparam int OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [OW-1:0]             grant_id,
  output logic                      busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state_r;
  logic [OW-1:0]     owner_r;
  logic [OW-1:0]     last_owner_r;
  logic [CW-1:0]     beat_cnt_r;
  logic [OW-1:0]     next_owner_s;
  logic              found_s;
  int                idx_s;
  logic              active_s;
  logic              xfer_s;
  logic              owner_valid_s;
  logic [DATA_W-1:0] owner_data_s;

  // Pick the next owner: first valid slot after last_owner, wrapping mod NUM_REQ
  always_comb begin
    next_owner_s = last_owner_r;
    found_s      = 1'b0;
    idx_s        = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s = (int'(last_owner_r) + i) % NUM_REQ;
      if (!found_s && req_valid[idx_s]) begin
        next_owner_s = OW'(idx_s);
        found_s      = 1'b1;
      end else begin
        found_s      = found_s;
      end
    end
`ifdef FIFO_ARB_PRIO_EN
    // Requester 0 overrides; the loop above already rotates the others
    if (req_valid[0]) begin
      next_owner_s = '0;
    end else begin
      next_owner_s = next_owner_s;
    end
`endif
  end

  // Write-port steering for the current owner; gated off while reset is applied
  always_comb begin
    owner_valid_s = req_valid[owner_r];
    owner_data_s  = req_data[owner_r*DATA_W +: DATA_W];
    active_s      = (state_r == GRANT) && !rst;
    xfer_s        = active_s && owner_valid_s && !fifo_full;
    req_ready     = '0;
    fifo_data     = '0;
    if (active_s) begin
      req_ready[owner_r] = !fifo_full;
      fifo_data          = owner_data_s;
    end else begin
      req_ready = '0;
      fifo_data = '0;
    end
    fifo_wr = xfer_s;
  end

  assign grant_id = owner_r;
  assign busy     = (state_r == GRANT);

  // Grant FSM: one IDLE cycle of registered arbitration between bursts
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= '0;
      last_owner_r <= OW'(NUM_REQ - 1);
      beat_cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req_valid) begin
            owner_r    <= next_owner_s;
            state_r    <= GRANT;
            beat_cnt_r <= '0;
          end
        end
        GRANT: begin
          if (xfer_s) begin
            if (beat_cnt_r == CW'(MAX_BURST - 1)) begin
              state_r      <= IDLE;
              last_owner_r <= owner_r;
              beat_cnt_r   <= '0;
            end else begin
              beat_cnt_r <= beat_cnt_r + CW'(1);
            end
          end else if (!owner_valid_s) begin
            // Owner went idle; a full FIFO alone never releases the grant
            state_r      <= IDLE;
            last_owner_r <= owner_r;
            beat_cnt_r   <= '0;
          end
        end
        default: begin
          state_r    <= IDLE;
          beat_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producers are modelled as per-requester data lists
// popped on valid&ready; every cycle's outputs are recorded and compared to hand-derived values.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic             clock = 1'b0;
  logic             rst = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic             fifo_full = 1'b0;
  logic             fifo_wr;
  logic [DW-1:0]    fifo_data;
  logic [1:0]       grant_id;
  logic             busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] pdata [NR][16];
  int         plen [NR];
  int         pidx [NR];
  logic [NR-1:0] en = '0;

  int         cyc = 0;
  logic       h_wr [64];
  logic [7:0] h_data [64];
  logic [3:0] h_ready [64];
  logic [1:0] h_gid [64];
  logic       h_busy [64];
  int         log_n = 0;
  logic [7:0] log_data [64];
  logic [1:0] log_gid [64];
  int         log_cyc [64];

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic load(input int p, input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++) pdata[p][j] = 8'(base + 8'(j));
    plen[p] = n;
    pidx[p] = 0;
  endtask

  task automatic cycle();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = en[i] && (pidx[i] < plen[i]);
      req_data[i*DW +: DW] = (pidx[i] < plen[i]) ? pdata[i][pidx[i]] : 8'h00;
    end
    #1;
    if (cyc < 64) begin
      h_wr[cyc] = fifo_wr; h_data[cyc] = fifo_data; h_ready[cyc] = req_ready;
      h_gid[cyc] = grant_id; h_busy[cyc] = busy;
    end
    if (fifo_wr === 1'b1 && log_n < 64) begin
      log_data[log_n] = fifo_data; log_gid[log_n] = grant_id; log_cyc[log_n] = cyc;
      log_n++;
    end
    @(posedge clock);
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && h_ready[cyc < 64 ? cyc : 63][i]) pidx[i]++;
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    en = '0; fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin plen[i] = 0; pidx[i] = 0; end
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    cyc = 0; log_n = 0;
  endtask

  task automatic test_reset();
    do_reset();
    cycle();
    checks++; if (h_ready[0] !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", h_ready[0]); end
    checks++; if (h_wr[0] !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", h_wr[0]); end
    checks++; if (h_data[0] !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", h_data[0]); end
    checks++; if (h_gid[0] !== 2'd0) begin failures++; $display("FAIL reset_gid got=%0d exp=0", h_gid[0]); end
    checks++; if (h_busy[0] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", h_busy[0]); end
  endtask

  task automatic test_single_producer();
    do_reset();
    load(0, 8'hA0, 6);
    en = 4'b0001;
    for (int k = 0; k < 10; k++) cycle();
    checks++; if (log_n !== 6) begin failures++; $display("FAIL single_count got=%0d exp=6", log_n); end
    for (int k = 0; k < 6 && k < log_n; k++) begin
      checks++;
      if (log_data[k] !== 8'(8'hA0 + 8'(k)) || log_gid[k] !== 2'd0 || log_cyc[k] !== ((k < 4) ? 1 + k : 2 + k)) begin
        failures++;
        $display("FAIL single_beat%0d got data=%h gid=%0d cyc=%0d exp data=%h gid=0 cyc=%0d",
                 k, log_data[k], log_gid[k], log_cyc[k], 8'(8'hA0 + 8'(k)), (k < 4) ? 1 + k : 2 + k);
      end
    end
    checks++; if (h_busy[5] !== 1'b0) begin failures++; $display("FAIL single_gap_busy got=%b exp=0", h_busy[5]); end
    checks++; if (h_busy[9] !== 1'b0) begin failures++; $display("FAIL single_end_busy got=%b exp=0", h_busy[9]); end
  endtask

  task automatic test_back_to_back();
    int b, j, own, ecyc;
    logic [7:0] edata;
    do_reset();
    for (int i = 0; i < NR; i++) load(i, 8'(16 * i), 8);
    en = 4'b1111;
    for (int k = 0; k < 25; k++) cycle();
    en = '0;
    checks++; if (log_n !== 20) begin failures++; $display("FAIL rr_count got=%0d exp=20", log_n); end
    for (int k = 0; k < 20 && k < log_n; k++) begin
      b = k / 4; j = k % 4; own = b % 4;
      edata = 8'(16 * own + ((b == 4) ? 4 + j : j));
      ecyc = 1 + 5 * b + j;
      checks++;
      if (log_data[k] !== edata || log_gid[k] !== 2'(own) || log_cyc[k] !== ecyc) begin
        failures++;
        $display("FAIL rr_beat%0d got data=%h gid=%0d cyc=%0d exp data=%h gid=%0d cyc=%0d",
                 k, log_data[k], log_gid[k], log_cyc[k], edata, own, ecyc);
      end
    end
    for (int g = 1; g <= 4; g++) begin
      checks++;
      if (h_busy[5 * g] !== 1'b0) begin failures++; $display("FAIL rr_gap%0d busy got=%b exp=0", g, h_busy[5 * g]); end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    load(2, 8'h20, 4);
    en = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      fifo_full = (k >= 3 && k <= 7);
      cycle();
    end
    fifo_full = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      checks++;
      if (h_wr[k] !== 1'b0 || h_ready[k] !== 4'b0000 || h_gid[k] !== 2'd2 || h_busy[k] !== 1'b1) begin
        failures++;
        $display("FAIL full_hold_c%0d got wr=%b ready=%b gid=%0d busy=%b exp wr=0 ready=0000 gid=2 busy=1",
                 k, h_wr[k], h_ready[k], h_gid[k], h_busy[k]);
      end
    end
    checks++; if (h_data[3] !== 8'h22) begin failures++; $display("FAIL full_data got=%h exp=22", h_data[3]); end
    checks++; if (log_n !== 4) begin failures++; $display("FAIL full_count got=%0d exp=4", log_n); end
    checks++;
    if (log_n >= 4 && (log_data[3] !== 8'h23 || log_cyc[3] !== 9 || log_cyc[2] !== 8)) begin
      failures++;
      $display("FAIL full_resume got data=%h cyc=%0d/%0d exp data=23 cyc=8/9", log_data[3], log_cyc[2], log_cyc[3]);
    end
    checks++; if (h_busy[10] !== 1'b0) begin failures++; $display("FAIL full_release busy got=%b exp=0", h_busy[10]); end
  endtask

  task automatic test_early_release();
    do_reset();
    load(1, 8'h51, 2);
    load(3, 8'h70, 4);
    en = 4'b1010;
    for (int k = 0; k < 10; k++) cycle();
    checks++; if (log_n !== 6) begin failures++; $display("FAIL early_count got=%0d exp=6", log_n); end
    checks++;
    if (log_gid[1] !== 2'd1 || log_data[1] !== 8'h52 || log_cyc[1] !== 2) begin
      failures++; $display("FAIL early_owner1 got gid=%0d data=%h cyc=%0d exp gid=1 data=52 cyc=2", log_gid[1], log_data[1], log_cyc[1]);
    end
    checks++; if (h_busy[4] !== 1'b0) begin failures++; $display("FAIL early_idle busy got=%b exp=0", h_busy[4]); end
    checks++;
    if (log_gid[2] !== 2'd3 || log_data[2] !== 8'h70 || log_cyc[2] !== 5) begin
      failures++; $display("FAIL early_next got gid=%0d data=%h cyc=%0d exp gid=3 data=70 cyc=5", log_gid[2], log_data[2], log_cyc[2]);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    load(3, 8'h30, 4);
    load(0, 8'h0F, 1);
    for (int k = 0; k < 8; k++) begin
      rst = (k == 3);
      en = (k >= 4) ? 4'b1001 : 4'b1000;
      cycle();
    end
    rst = 1'b0;
    checks++; if (h_wr[2] !== 1'b1 || h_data[2] !== 8'h31) begin failures++; $display("FAIL midrst_pre got wr=%b data=%h exp wr=1 data=31", h_wr[2], h_data[2]); end
    checks++; if (h_wr[3] !== 1'b0) begin failures++; $display("FAIL midrst_during wr got=%b exp=0", h_wr[3]); end
    checks++;
    if (h_busy[4] !== 1'b0 || h_wr[4] !== 1'b0 || h_ready[4] !== 4'b0000 || h_gid[4] !== 2'd0) begin
      failures++;
      $display("FAIL midrst_after got busy=%b wr=%b ready=%b gid=%0d exp busy=0 wr=0 ready=0000 gid=0", h_busy[4], h_wr[4], h_ready[4], h_gid[4]);
    end
    checks++;
    if (h_gid[5] !== 2'd0 || h_wr[5] !== 1'b1 || h_data[5] !== 8'h0F) begin
      failures++; $display("FAIL midrst_regrant got gid=%0d wr=%b data=%h exp gid=0 wr=1 data=0f", h_gid[5], h_wr[5], h_data[5]);
    end
  endtask

  task automatic test_priority();
    logic [1:0] exp_g4;
    logic [7:0] exp_d4;
`ifdef FIFO_ARB_PRIO_EN
    exp_g4 = 2'd0; exp_d4 = 8'h02;
`else
    exp_g4 = 2'd1; exp_d4 = 8'h11;
`endif
    do_reset();
    load(0, 8'h01, 9);
    load(1, 8'h11, 4);
    for (int k = 0; k < 12; k++) begin
      en = (k <= 1) ? 4'b0001 : ((k == 2) ? 4'b0000 : 4'b0011);
      cycle();
    end
    en = '0;
    checks++; if (h_busy[3] !== 1'b0) begin failures++; $display("FAIL prio_idle busy got=%b exp=0", h_busy[3]); end
    checks++;
    if (h_gid[4] !== exp_g4 || h_data[4] !== exp_d4 || h_wr[4] !== 1'b1) begin
      failures++; $display("FAIL prio_first got gid=%0d data=%h wr=%b exp gid=%0d data=%h wr=1", h_gid[4], h_data[4], h_wr[4], exp_g4, exp_d4);
    end
    checks++; if (h_gid[9] !== 2'd0 || h_wr[9] !== 1'b1) begin failures++; $display("FAIL prio_second got gid=%0d wr=%b exp gid=0 wr=1", h_gid[9], h_wr[9]); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single_producer();
    test_back_to_back();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
